// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between the M-stage byte-enable logic and the
// data-memory bus. Ports: store in_*, load probe ld_*, stall, memory m_*, count/empty.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_wdata,
    input  logic [3:0]    in_byteen,
    input  logic          ld_req,
    input  logic [31:0]   ld_addr,
    output logic          stall,
    output logic          m_valid,
    output logic [31:0]   m_addr,
    output logic [31:0]   m_wdata,
    output logic [3:0]    m_byteen,
    input  logic          m_ready,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int IW = CW - 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    sb_entry_t         mem [DEPTH];
    sb_entry_t         head;
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [DEPTH-1:0]  hit_vec;
    logic              full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              ld_hit;

    assign wr_idx   = wr_ptr[IW-1:0];
    assign rd_idx   = rd_ptr[IW-1:0];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = |in_byteen;
    assign pop      = m_valid && m_ready;
    assign push     = push_req && !full && !ld_hit;

    // An entry is occupied when its distance from the head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [IW-1:0] off;
        assign off        = IW'(g) - rd_idx;
        assign hit_vec[g] = ({1'b0, off} < count)
                          && (mem[g].addr == ld_addr[31:2]);
    end

    assign ld_hit = ld_req && |hit_vec;
    assign stall  = (push_req && full) || ld_hit;

    assign head     = mem[rd_idx];
    assign m_valid  = !empty;
    assign m_addr   = {head.addr, 2'b00};
    assign m_wdata  = head.data;
    assign m_byteen = m_valid ? head.be : 4'b0000;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= '{addr: in_addr[31:2],
                             data: in_wdata,
                             be:   in_byteen};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer.
// Inputs change 1ns after posedge; memory pops are logged on negedge.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_byteen;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        stall;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_ready;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [31:0] log_q[$];

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_byteen(in_byteen),
        .ld_req(ld_req), .ld_addr(ld_addr), .stall(stall),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_ready(m_ready),
        .count(count), .empty(empty)
    );

    always @(negedge clk)
        if (rst_n && m_valid && m_ready) log_q.push_back(m_wdata);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_byteen = 4'b0000;
        in_addr   = '0;
        in_wdata  = '0;
        ld_req    = 1'b0;
        ld_addr   = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (!empty && n < 20) begin
            step();
            n++;
        end
        m_ready = 1'b0;
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain_timeout count=%0d expected 0", count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        m_ready = 1'b0;
        #3;
        checks++;
        if (m_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1
            || stall !== 1'b0 || m_byteen !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state v=%b c=%0d e=%b s=%b be=%b expected 0 0 1 0 0000",
                     m_valid, count, empty, stall, m_byteen);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        log_q.delete();
        m_ready   = 1'b1;
        in_addr   = 32'h0000_1003;
        in_byteen = 4'b1000;
        in_wdata  = 32'hAB00_0000;
        #1;
        checks++;
        if (stall !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre stall=%b m_valid=%b expected 0 0", stall, m_valid);
        end
        step();
        idle_in();
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h0000_1000
            || m_byteen !== 4'b1000 || m_wdata !== 32'hAB00_0000
            || count !== 3'd1) begin
            errors++;
            $display("FAIL single_head v=%b a=%h be=%b d=%h c=%0d expected 1 00001000 1000 ab000000 1",
                     m_valid, m_addr, m_byteen, m_wdata, count);
        end
        step();
        m_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || m_valid !== 1'b0 || m_byteen !== 4'b0000
            || log_q.size() != 1) begin
            errors++;
            $display("FAIL single_pop c=%0d v=%b be=%b pops=%0d expected 0 0 0000 1",
                     count, m_valid, m_byteen, log_q.size());
        end
    endtask

    task automatic test_fill();
        log_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_addr   = 32'h0000_4000 + 32'(i * 4);
            in_wdata  = 32'hF000_0000 + 32'(i);
            in_byteen = 4'b1111;
            step();
        end
        in_addr  = 32'h0000_4010;
        in_wdata = 32'hF000_0004;
        #1;
        checks++;
        if (count !== 3'd4 || stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_full c=%0d stall=%b expected 4 1", count, stall);
        end
        step();
        checks++;
        if (count !== 3'd4 || stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_hold c=%0d stall=%b expected 4 1", count, stall);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL fill_no_ready_path stall=%b expected 1", stall);
        end
        step();
        m_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || stall !== 1'b0) begin
            errors++;
            $display("FAIL fill_release c=%0d stall=%b expected 3 0", count, stall);
        end
        step();
        idle_in();
        checks++;
        if (count !== 3'd4 || m_wdata !== 32'hF000_0001) begin
            errors++;
            $display("FAIL fill_accept c=%0d head=%h expected 4 f0000001", count, m_wdata);
        end
        drain();
        checks++;
        if (log_q.size() != 5 || log_q[0] !== 32'hF000_0000
            || log_q[4] !== 32'hF000_0004) begin
            errors++;
            $display("FAIL fill_order pops=%0d expected 5 f0000000..f0000004", log_q.size());
        end
    endtask

    task automatic test_load_hazard();
        m_ready   = 1'b0;
        in_addr   = 32'h0000_2004;
        in_wdata  = 32'h1234_5678;
        in_byteen = 4'b0001;
        step();
        idle_in();
        ld_req  = 1'b1;
        ld_addr = 32'h0000_2006;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ld_hit stall=%b expected 1", stall);
        end
        step();
        step();
        m_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ld_hit_popping stall=%b expected 1", stall);
        end
        step();
        m_ready = 1'b0;
        checks++;
        if (stall !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL ld_hit_clear stall=%b c=%0d expected 0 0", stall, count);
        end
        ld_req    = 1'b0;
        in_addr   = 32'h0000_2004;
        in_byteen = 4'b1111;
        step();
        idle_in();
        ld_req  = 1'b1;
        ld_addr = 32'h0000_2008;
        #1;
        checks++;
        if (stall !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL ld_miss stall=%b c=%0d expected 0 1", stall, count);
        end
        ld_req = 1'b0;
        drain();
    endtask

    task automatic test_wrap();
        int i;
        int n;
        bit max_ok;
        log_q.delete();
        i = 0;
        n = 0;
        max_ok = 1'b1;
        while (i < 10 && n < 200) begin
            in_addr   = 32'h0000_3000 + 32'(i * 4);
            in_wdata  = 32'(i);
            in_byteen = 4'b1111;
            m_ready   = 1'($urandom_range(0, 1));
            #1;
            if (!stall) i++;
            step();
            if (count > 3'd4) max_ok = 1'b0;
            n++;
        end
        idle_in();
        checks++;
        if (i != 10) begin
            errors++;
            $display("FAIL wrap_timeout pushed=%0d expected 10", i);
        end
        drain();
        checks++;
        if (!max_ok) begin
            errors++;
            $display("FAIL wrap_count count exceeded 4");
        end
        checks++;
        if (log_q.size() != 10) begin
            errors++;
            $display("FAIL wrap_pops pops=%0d expected 10", log_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (log_q[k] !== 32'(k)) begin
                    errors++;
                    $display("FAIL wrap_order[%0d] got=%0d expected %0d", k, log_q[k], k);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_addr   = 32'h0000_5000 + 32'(i * 4);
            in_wdata  = 32'hC0 + 32'(i);
            in_byteen = 4'b0011;
            step();
        end
        in_addr  = 32'h0000_5008;
        in_wdata = 32'hC2;
        m_ready  = 1'b1;
        step();
        idle_in();
        m_ready = 1'b0;
        checks++;
        if (count !== 3'd2 || m_wdata !== 32'hC1 || m_addr !== 32'h0000_5004) begin
            errors++;
            $display("FAIL push_pop c=%0d head=%h a=%h expected 2 000000c1 00005004",
                     count, m_wdata, m_addr);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_addr   = 32'h0000_6000 + 32'(i * 4);
            in_wdata  = 32'(i);
            in_byteen = 4'b1111;
            step();
        end
        idle_in();
        ld_req  = 1'b1;
        ld_addr = 32'h0000_6000;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1
            || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid v=%b c=%0d e=%b s=%b expected 0 0 1 0",
                     m_valid, count, empty, stall);
        end
        ld_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (count !== 3'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard c=%0d v=%b expected 0 0", count, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_load_hazard();
        test_wrap();
        test_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
